// File: rtl/filt_pkg.sv
// Shared types and constants for the XADC-to-FIR feeder.
package filt_pkg;

    localparam int XADC_DATA_SIZE_DEF = 16;

    localparam logic [1:0] FILT_SEL_LPF = 2'b00;
    localparam logic [1:0] FILT_SEL_HPF = 2'b01;
    localparam logic [1:0] FILT_SEL_BPF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_OUT
    } feed_state_t;

endpackage

// File: rtl/filt_sample_fifo.sv
// Small synchronous sample FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module filt_sample_fifo #(
    parameter int WIDTH   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/filt_feeder.sv
// Sequences buffered ADC samples through the FIR core one at a time and
// streams each result out on a valid/ready interface.
module filt_feeder
    import filt_pkg::*;
#(
    parameter int XADC_DATA_SIZE = XADC_DATA_SIZE_DEF,
    parameter int FIFO_AW        = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adc_valid,
    input  logic [XADC_DATA_SIZE-1:0] adc_data,
    input  logic [1:0]                filt_select_i,
    output logic [1:0]                filt_select_o,
    output logic                      filt_start,
    output logic [XADC_DATA_SIZE-1:0] filt_input,
    input  logic                      filt_done,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    output logic                      out_valid,
    output logic [XADC_DATA_SIZE-1:0] out_data,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          overflow_cnt,
    output logic                      timeout_err
);

    // One counter serves both the start pulse and the WAIT timeout.
    localparam int CW = $clog2(TIMEOUT_CYCLES + START_CYCLES + 1);

    feed_state_t               state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [XADC_DATA_SIZE-1:0] input_q, input_d;
    logic [1:0]                sel_q, sel_d;
    logic [XADC_DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      timeout_q, timeout_d;
    logic [CNT_W-1:0]          ovf_q, ovf_d;
    logic                      done_q, done_d;
    logic                      rise_q, rise_d;

    logic                      fifo_pop;
    logic [XADC_DATA_SIZE-1:0] fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;

    filt_sample_fifo #(
        .WIDTH   (XADC_DATA_SIZE),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (adc_valid),
        .pop   (fifo_pop),
        .din   (adc_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        input_d     = input_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        timeout_d   = timeout_q;
        ovf_d       = ovf_q;
        fifo_pop    = 1'b0;
        done_d      = filt_done;
        // The rise is registered once more, so a result lands two cycles after done.
        rise_d      = filt_done & ~done_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !filt_done) begin
                    fifo_pop = 1'b1;
                    input_d  = fifo_dout;
                    sel_d    = filt_select_i;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                if (rise_q) begin
                    out_data_d  = filt_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (adc_valid && fifo_full && !fifo_pop && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            input_q     <= '0;
            sel_q       <= FILT_SEL_LPF;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ovf_q       <= '0;
            done_q      <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            input_q     <= input_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            rise_q      <= rise_d;
        end
    end

    assign filt_start    = (state_q == ST_START);
    assign filt_input    = input_q;
    assign filt_select_o = sel_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow_cnt  = ovf_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_filt_feeder.sv
// Directed bench for filt_feeder with a behavioural FIR core model and
// an operand scoreboard; results are expected to be operand >> 1.
module tb_filt_feeder;
    import filt_pkg::*;

    localparam int W              = 16;
    localparam int FIFO_AW        = 4;
    localparam int START_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam int CNT_W          = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          adc_valid = 1'b0;
    logic [W-1:0]  adc_data = '0;
    logic [1:0]    filt_select_i = FILT_SEL_LPF;
    logic [1:0]    filt_select_o;
    logic          filt_start;
    logic [W-1:0]  filt_input;
    logic          filt_done;
    logic [W-1:0]  filt_result;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic [CNT_W-1:0] overflow_cnt;
    logic          timeout_err;

    filt_feeder #(
        .XADC_DATA_SIZE (W),
        .FIFO_AW        (FIFO_AW),
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .filt_select_i (filt_select_i),
        .filt_select_o (filt_select_o),
        .filt_start    (filt_start),
        .filt_input    (filt_input),
        .filt_done     (filt_done),
        .filt_result   (filt_result),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .busy          (busy),
        .overflow_cnt  (overflow_cnt),
        .timeout_err   (timeout_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // core model: result = operand >> 1, done held for 3 cycles
    logic         core_on = 1'b1;
    int           core_delay = 5;
    int           done_cyc = 0;
    logic [W-1:0] core_op;

    initial begin
        filt_done   = 1'b0;
        filt_result = '0;
        forever begin
            @(negedge clk);
            if (core_on && filt_start === 1'b1) begin
                core_op = filt_input;
                repeat (core_delay) @(negedge clk);
                filt_result = core_op >> 1;
                filt_done   = 1'b1;
                done_cyc    = cyc;
                repeat (3) @(negedge clk);
                filt_done = 1'b0;
            end
        end
    end

    // start-pulse monitor
    int           start_cnt = 0;
    int           run = 0;
    int           wait_cyc = 0;
    logic [W-1:0] last_op = '0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            run = 0;
        end else if (filt_start === 1'b1) begin
            if (run == 0) begin
                start_cnt++;
                last_op = filt_input;
            end
            run++;
        end else if (run != 0) begin
            check("start_width", run, START_CYCLES);
            run = 0;
            wait_cyc = cyc;
        end
    end

    // scoreboard of expected operands
    logic [W-1:0] exp_q[$];
    int           ov_cyc = 0;

    task automatic push_sample(input logic [W-1:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic consume_one(input int hold, input bit pp, input logic [W-1:0] pp_data);
        logic [W-1:0] op;
        logic [W-1:0] held;
        bit           stable;
        int           t;
        op = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        t = 0;
        while (out_valid !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_wait", out_valid, 1);
        if (out_valid !== 1'b1) return;
        ov_cyc = cyc;
        check("out_data", out_data, op >> 1);
        check("operand", last_op, op);
        stable = 1'b1;
        held   = out_data;
        repeat (hold) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held) stable = 1'b0;
        end
        if (hold > 0) check("out_hold", stable, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (pp) begin
            adc_valid = 1'b1;
            adc_data  = pp_data;
        end
        check("out_valid_clr", out_valid, 0);
        if (pp) begin
            @(negedge clk);
            adc_valid = 1'b0;
        end
    endtask

    int s0;
    int t;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_start", filt_start, 0);
        check("rst_input", filt_input, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_sel", filt_select_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // single sample with latency checks
        adc_valid = 1'b1;
        adc_data  = 16'd1234;
        exp_q.push_back(16'd1234);
        @(negedge clk);
        adc_valid = 1'b0;
        check("lat_e1_start", filt_start, 0);
        check("lat_e1_busy", busy, 1);
        @(negedge clk);
        check("lat_e2_start", filt_start, 1);
        check("lat_e2_input", filt_input, 1234);
        @(negedge clk);
        check("lat_e3_start", filt_start, 1);
        @(negedge clk);
        check("lat_e4_start", filt_start, 0);
        check("lat_e4_input", filt_input, 1234);
        consume_one(4, 1'b0, '0);
        check("result_latency", ov_cyc - done_cyc, 2);
        repeat (5) @(negedge clk);
        check("single_busy", busy, 0);
        check("single_starts", start_cnt, 1);

        // burst of 20 against a stalled core, then push on the pop cycle
        core_delay = 100;
        for (int i = 0; i < 20; i++) begin
            adc_valid = 1'b1;
            adc_data  = W'(i);
            if (i <= 16) exp_q.push_back(W'(i));
            @(negedge clk);
        end
        adc_valid = 1'b0;
        check("burst_ovf", overflow_cnt, 3);
        check("burst_busy", busy, 1);
        core_delay = 5;
        consume_one(8, 1'b1, 16'd99);
        exp_q.push_back(16'd99);
        @(negedge clk);
        check("pushpop_ovf", overflow_cnt, 3);
        while (exp_q.size() > 0) consume_one(0, 1'b0, '0);
        repeat (6) @(negedge clk);
        check("burst_idle_busy", busy, 0);

        // backpressure with three queued samples
        s0 = start_cnt;
        for (int i = 0; i < 3; i++) begin
            adc_valid = 1'b1;
            adc_data  = W'(300 + i);
            exp_q.push_back(W'(300 + i));
            @(negedge clk);
        end
        adc_valid = 1'b0;
        consume_one(50, 1'b0, '0);
        check("bp_one_start", start_cnt - s0, 1);
        consume_one(0, 1'b0, '0);
        consume_one(0, 1'b0, '0);
        check("bp_all_starts", start_cnt - s0, 3);

        // select change while waiting
        repeat (5) @(negedge clk);
        core_delay    = 20;
        filt_select_i = FILT_SEL_LPF;
        exp_q.push_back(16'd400);
        push_sample(16'd400);
        repeat (8) @(negedge clk);
        filt_select_i = FILT_SEL_BPF;
        repeat (4) @(negedge clk);
        check("sel_hold_wait", filt_select_o, FILT_SEL_LPF);
        consume_one(0, 1'b0, '0);
        check("sel_hold_idle", filt_select_o, FILT_SEL_LPF);
        repeat (5) @(negedge clk);
        exp_q.push_back(16'd401);
        push_sample(16'd401);
        @(negedge clk);
        check("sel_new_start", filt_start, 1);
        check("sel_new", filt_select_o, FILT_SEL_BPF);
        consume_one(0, 1'b0, '0);
        core_delay = 5;

        // timeout with a silent core, then normal recovery
        repeat (5) @(negedge clk);
        core_on = 1'b0;
        push_sample(16'd500);
        t = 0;
        while (timeout_err !== 1'b1 && t < 1500) begin
            @(negedge clk);
            t++;
        end
        check("to_flag", timeout_err, 1);
        check("to_cycles", cyc - wait_cyc, TIMEOUT_CYCLES);
        check("to_no_out", out_valid, 0);
        @(negedge clk);
        check("to_idle_busy", busy, 0);
        core_on = 1'b1;
        exp_q.push_back(16'd600);
        push_sample(16'd600);
        consume_one(0, 1'b0, '0);
        check("to_sticky", timeout_err, 1);

        // asynchronous reset in the middle of START
        repeat (5) @(negedge clk);
        core_on = 1'b0;
        push_sample(16'd700);
        t = 0;
        while (filt_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_seen", filt_start, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_start", filt_start, 0);
        check("rst_mid_timeout", timeout_err, 0);
        check("rst_mid_ovf", overflow_cnt, 0);
        check("rst_mid_input", filt_input, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sel", filt_select_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_start", filt_start, 0);
        core_on = 1'b1;
        exp_q.push_back(16'd800);
        push_sample(16'd800);
        consume_one(0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/filt_feeder.md
Name: filt_feeder

Overview:
Upstream sequencer between the XADC sample stream and the `filters` FIR core.
- Buffers incoming ADC samples in a small FIFO.
- Issues one `filt_start` pulse per sample and holds the operand stable until `filt_done`.
- Returns each `filt_result` on a valid/ready output stream to the display/capture path.
- Counts dropped samples and flags a stalled filter with a timeout.

Parameters:
XADC_DATA_SIZE, 16, sample and result width in bits
FIFO_AW, 4, log2 of input FIFO depth (16 entries)
START_CYCLES, 2, width of the `filt_start` pulse in clk cycles (at least 1)
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before abort
CNT_W, 16, width of the overflow counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
adc_valid  in  1  sample strobe; one sample per cycle while high
adc_data  in  XADC_DATA_SIZE  ADC sample
filt_select_i  in  2  requested filter (00 LPF, 01 HPF, 10 BPF)
filt_select_o  out  2  filter select presented to the core
filt_start  out  1  start pulse to the core
filt_input  out  XADC_DATA_SIZE  operand to the core
filt_done  in  1  core completion level
filt_result  in  XADC_DATA_SIZE  core result
out_valid  out  1  result available
out_data  out  XADC_DATA_SIZE  filtered sample
out_ready  in  1  consumer accepts
busy  out  1  FSM not in IDLE, or FIFO not empty
overflow_cnt  out  CNT_W  dropped samples, saturating
timeout_err  out  1  sticky; set on a WAIT timeout

Behaviour:
- Reset (asynchronous assert, synchronous release): every output is 0, FSM is in IDLE, FIFO is empty, counters are 0, `filt_select_o` is 00.
- FIFO push: `adc_valid` while not full. If full with no pop that cycle, the sample is dropped and `overflow_cnt` increments, saturating at all-ones.
- FIFO simultaneous push and pop when full: the pop frees a slot, the push is accepted and nothing is dropped. Pointers wrap modulo 2^FIFO_AW.
- Done edge detection: `filt_done` is registered; `done_rise` = `filt_done` & ~`done_q`.
- IDLE: when the FIFO is non-empty and `filt_done` is 0, pop the head into `filt_input` and latch `filt_select_i` into `filt_select_o`, then go to START. `filt_select_o` changes only on this transition.
- START: `filt_start` is 1 for exactly START_CYCLES cycles, then go to WAIT. `filt_input` is held.
- WAIT: on `done_rise`, capture `filt_result` into `out_data` and go to OUT. If TIMEOUT_CYCLES elapse with no rise, set `timeout_err`, discard the sample and go to IDLE.
- Done edges outside WAIT are ignored.
- OUT: `out_valid` is 1 with `out_data` held. On `out_valid` & `out_ready`, clear `out_valid` and go to IDLE.
- Latency, empty FIFO and immediate done: `adc_valid` at cycle 0, FIFO write at edge 1, IDLE pop at edge 2, `filt_start` high for cycles 2..(1+START_CYCLES).
- Latency, result side: `out_valid` asserts 2 cycles after `filt_done` rises (edge-detect register, then capture).
- Back-to-back operation: the next start is at least 1 cycle after the output handshake and only after `filt_done` has fallen.
- Reset mid-operation: immediate return to the reset state. The FIFO contents and any in-flight result are lost.
- `timeout_err` clears only on `rst`.

Decomposition:
- Package `filt_pkg`:
  - FSM state enum (IDLE, START, WAIT, OUT)
  - FILT_SEL_LPF/HPF/BPF constants
  - default XADC_DATA_SIZE
- Sub-module `filt_sample_fifo`:
  - synchronous FIFO with parameters width and FIFO_AW
  - ports: `push`, `pop`, `din`, `dout` (registered head), `full`, `empty`
  - handles the push-when-full, simultaneous push/pop case
- Top holds the FSM, the start-pulse and timeout counters, the done edge detect, and the overflow counter.

Test Plan:
- Single sample: `adc_data` = 1234 for one cycle; model the core returning 617 5 cycles after the start pulse.
  - Exactly one 2-cycle `filt_start` with `filt_input` = 1234.
  - `out_data` = 617 with `out_valid` until `out_ready`.
  - `busy` falls afterwards.
- Burst: 20 consecutive `adc_valid` samples 0..19 with the core stalled for 100 cycles.
  - Samples 0..16 kept: sample 0 is popped into the operand register, samples 1..16 fill the FIFO.
  - Samples 17..19 dropped; `overflow_cnt` = 3.
  - Results emerge in order 0..16.
- Full FIFO, simultaneous push/pop: push exactly on the pop cycle.
  - No drop; `overflow_cnt` unchanged.
- Backpressure: `out_ready` held low for 50 cycles with 3 samples queued.
  - Only one start is issued; `out_data` stays stable.
  - Remaining starts follow each accepted handshake.
- Select change: `filt_select_i` toggles 00 to 10 while in WAIT.
  - `filt_select_o` stays 00 until the next IDLE-to-START transition, then becomes 10.
- Timeout and reset: the core never asserts done.
  - After 1024 WAIT cycles `timeout_err` = 1 and the FSM returns to IDLE, then processes the next sample normally.
  - Asserting `rst` mid-START drops `filt_start` and clears all outputs and `timeout_err` asynchronously.
